// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: FSM state encoding and state width.
package icache_pkg;

  localparam int unsigned IcacheStateW = 1;

  typedef enum logic [IcacheStateW-1:0] {
    StIdle = 1'b0,
    StMiss = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetcher-side and memory-controller-side handshake signals of the instruction cache.
interface icache_if;

  logic        inst_IF_req;
  logic [31:0] inst_IF_addr;
  logic        inst_IF_flag;
  logic [31:0] inst_IF;
  logic        inst_MC_req;
  logic [31:0] inst_MC_addr;
  logic        inst_MC_flag;
  logic [31:0] inst_MC;

  // The cache itself.
  modport slave (
    input  inst_IF_req,
    input  inst_IF_addr,
    output inst_IF_flag,
    output inst_IF,
    output inst_MC_req,
    output inst_MC_addr,
    input  inst_MC_flag,
    input  inst_MC
  );

  // The environment: fetcher plus memory controller.
  modport master (
    output inst_IF_req,
    output inst_IF_addr,
    input  inst_IF_flag,
    input  inst_IF,
    input  inst_MC_req,
    input  inst_MC_addr,
    output inst_MC_flag,
    output inst_MC
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with 1-cycle hits and single-word refills.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    rollback,
  icache_if.slave bus
);

  localparam int unsigned Lines = 1 << INDEX_WIDTH;
  localparam int unsigned TagW  = 32 - INDEX_WIDTH - 2;

  icache_state_e state_q, state_d;
  logic [Lines-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  logic        if_flag_q, if_flag_d;
  logic [31:0] if_data_q, if_data_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic        discard_q, discard_d;

  logic [INDEX_WIDTH-1:0] req_idx, miss_idx;
  logic [TagW-1:0]        req_tag, miss_tag;
  logic                   hit;
  logic                   fill_we;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.inst_IF_addr[1:0];

  assign req_idx  = bus.inst_IF_addr[INDEX_WIDTH+1:2];
  assign req_tag  = bus.inst_IF_addr[31:INDEX_WIDTH+2];
  // The outstanding miss address doubles as the latched fill address.
  assign miss_idx = mc_addr_q[INDEX_WIDTH+1:2];
  assign miss_tag = mc_addr_q[31:INDEX_WIDTH+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    if_flag_d = 1'b0;
    if_data_d = if_data_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    discard_d = discard_q;
    fill_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.inst_IF_req && !rollback) begin
          if (hit) begin
            if_flag_d = 1'b1;
            if_data_d = data_q[req_idx];
          end else begin
            mc_req_d  = 1'b1;
            mc_addr_d = {bus.inst_IF_addr[31:2], 2'b00};
            state_d   = StMiss;
          end
        end
      end
      StMiss: begin
        if (bus.inst_MC_flag) begin
          // The refill always lands; only delivery to the fetcher can be cancelled.
          fill_we           = 1'b1;
          valid_d[miss_idx] = 1'b1;
          mc_req_d          = 1'b0;
          discard_d         = 1'b0;
          state_d           = StIdle;
          if (!discard_q && !rollback) begin
            if_flag_d = 1'b1;
            if_data_d = bus.inst_MC;
          end
        end else if (rollback) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      if_flag_q <= 1'b0;
      if_data_q <= '0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      discard_q <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      if_flag_q <= if_flag_d;
      if_data_q <= if_data_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.inst_MC;
    end
  end

  assign bus.inst_IF_flag = if_flag_q;
  assign bus.inst_IF      = if_data_q;
  assign bus.inst_MC_req  = mc_req_q;
  assign bus.inst_MC_addr = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, hand-written stall/reset/rollback sequences, and
// randomized fetches checked against a line-level cache model.
module tb_icache;

  logic clk;
  logic rst;
  logic rdy;
  logic rollback;

  icache_if bus ();

  icache #(
    .INDEX_WIDTH(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .rollback(rollback),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one entry per line.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];

  typedef struct {
    logic [31:0] addr;
    int          rb_mode;  // 0 none, 1 rollback mid-miss, 2 rollback with the refill
    int          lat;
    logic [31:0] data;
    bit          exp_hit;
    bit          exp_flag;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic fetch(input string nm, input logic [31:0] a, input int rb_mode, input int lat,
                       input logic [31:0] d, input bit exp_hit, input bit exp_flag,
                       input logic [31:0] exp_inst);
    bus.inst_IF_req  = 1'b1;
    bus.inst_IF_addr = a;
    tick();
    if (exp_hit) begin
      check({nm, " hit flag"}, 32'(bus.inst_IF_flag), 32'd1);
      check({nm, " hit inst"}, bus.inst_IF, exp_inst);
      check({nm, " hit no mc_req"}, 32'(bus.inst_MC_req), 32'd0);
      bus.inst_IF_req = 1'b0;
      tick();
      check({nm, " hit flag drop"}, 32'(bus.inst_IF_flag), 32'd0);
    end else begin
      check({nm, " miss no flag"}, 32'(bus.inst_IF_flag), 32'd0);
      check({nm, " miss mc_req"}, 32'(bus.inst_MC_req), 32'd1);
      check({nm, " miss mc_addr"}, bus.inst_MC_addr, {a[31:2], 2'b00});
      for (int c = 0; c < lat; c++) begin
        if (rb_mode == 1 && c == 1) rollback = 1'b1;
        tick();
        if (rollback) begin
          rollback        = 1'b0;
          bus.inst_IF_req = 1'b0;
        end
        check({nm, " mc_req held"}, 32'(bus.inst_MC_req), 32'd1);
        check({nm, " mc_addr held"}, bus.inst_MC_addr, {a[31:2], 2'b00});
        check({nm, " no early flag"}, 32'(bus.inst_IF_flag), 32'd0);
      end
      bus.inst_MC_flag = 1'b1;
      bus.inst_MC      = d;
      if (rb_mode == 2) rollback = 1'b1;
      tick();
      bus.inst_MC_flag = 1'b0;
      bus.inst_MC      = $urandom;
      rollback         = 1'b0;
      check({nm, " fill flag"}, 32'(bus.inst_IF_flag), 32'(exp_flag));
      if (exp_flag) check({nm, " fill inst"}, bus.inst_IF, exp_inst);
      check({nm, " fill mc_req drop"}, 32'(bus.inst_MC_req), 32'd0);
      bus.inst_IF_req = 1'b0;
      tick();
      check({nm, " post-fill flag drop"}, 32'(bus.inst_IF_flag), 32'd0);
      m_valid[a[7:2]] = 1'b1;
      m_tag[a[7:2]]   = a[31:8];
      m_data[a[7:2]]  = d;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    rdy              = 1'b0;  // reset must act regardless of rdy
    rollback         = 1'b0;
    bus.inst_IF_req  = 1'b0;
    bus.inst_IF_addr = '0;
    bus.inst_MC_flag = 1'b0;
    bus.inst_MC      = '0;
    model_clear();
    tick();
    tick();
    check("reset flag", 32'(bus.inst_IF_flag), 32'd0);
    check("reset inst", bus.inst_IF, 32'd0);
    check("reset mc_req", 32'(bus.inst_MC_req), 32'd0);
    check("reset mc_addr", bus.inst_MC_addr, 32'd0);
    rst = 1'b0;
    rdy = 1'b1;
    tick();

    vecs[0] = '{32'h0000_0000, 0, 4, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013};
    vecs[1] = '{32'h0000_0000, 0, 0, 32'h0,         1'b1, 1'b1, 32'h0000_0013};
    vecs[2] = '{32'h0000_0100, 0, 3, 32'hFFF0_0093, 1'b0, 1'b1, 32'hFFF0_0093};
    vecs[3] = '{32'h0000_0000, 0, 2, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013};
    vecs[4] = '{32'h0000_0004, 1, 4, 32'h0010_0113, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'h0000_0004, 0, 0, 32'h0,         1'b1, 1'b1, 32'h0010_0113};
    vecs[6] = '{32'h0000_0007, 0, 0, 32'h0,         1'b1, 1'b1, 32'h0010_0113};
    vecs[7] = '{32'h0000_0100, 2, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{32'h0000_0100, 0, 0, 32'h0,         1'b1, 1'b1, 32'h0BAD_F00D};
    for (int i = 0; i < 9; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rb_mode, vecs[i].lat, vecs[i].data,
            vecs[i].exp_hit, vecs[i].exp_flag, vecs[i].exp_inst);
    end

    // rdy stall while a hit response is showing.
    bus.inst_IF_req  = 1'b1;
    bus.inst_IF_addr = 32'h0000_0100;
    tick();
    check("stall hit flag", 32'(bus.inst_IF_flag), 32'd1);
    rdy              = 1'b0;
    bus.inst_IF_addr = 32'h0000_0200;
    bus.inst_MC_flag = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall flag held", 32'(bus.inst_IF_flag), 32'd1);
      check("stall inst held", bus.inst_IF, 32'h0BAD_F00D);
      check("stall no mc_req", 32'(bus.inst_MC_req), 32'd0);
    end
    bus.inst_IF_req  = 1'b0;
    bus.inst_MC_flag = 1'b0;
    rdy              = 1'b1;
    tick();
    check("stall flag drop", 32'(bus.inst_IF_flag), 32'd0);
    check("stall still no mc_req", 32'(bus.inst_MC_req), 32'd0);

    // Reset in the middle of a miss, then a late refill pulse.
    bus.inst_IF_req  = 1'b1;
    bus.inst_IF_addr = 32'h0000_0008;
    tick();
    check("rstmiss mc_req", 32'(bus.inst_MC_req), 32'd1);
    tick();
    rst             = 1'b1;
    bus.inst_IF_req = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
    check("rstmiss mc_req drop", 32'(bus.inst_MC_req), 32'd0);
    check("rstmiss mc_addr", bus.inst_MC_addr, 32'd0);
    check("rstmiss flag", 32'(bus.inst_IF_flag), 32'd0);
    check("rstmiss inst", bus.inst_IF, 32'd0);
    bus.inst_MC_flag = 1'b1;
    bus.inst_MC      = 32'hDEAD_BEEF;
    tick();
    bus.inst_MC_flag = 1'b0;
    check("late mc_flag no flag", 32'(bus.inst_IF_flag), 32'd0);
    check("late mc_flag no mc_req", 32'(bus.inst_MC_req), 32'd0);
    fetch("post-reset", 32'h0000_0000, 0, 2, 32'h600D_F00D, 1'b0, 1'b1, 32'h600D_F00D);
    fetch("late fill not stored", 32'h0000_0008, 0, 1, 32'h1234_5678, 1'b0, 1'b1,
          32'h1234_5678);

    // Rollback in IDLE suppresses an otherwise-hitting request.
    bus.inst_IF_req  = 1'b1;
    bus.inst_IF_addr = 32'h0000_0000;
    rollback         = 1'b1;
    tick();
    rollback         = 1'b0;
    bus.inst_IF_req  = 1'b0;
    check("idle rollback no flag", 32'(bus.inst_IF_flag), 32'd0);
    check("idle rollback no mc_req", 32'(bus.inst_MC_req), 32'd0);
    tick();

    // Randomized fetches over a small address pool to mix hits, misses and conflicts.
    for (int n = 0; n < 80; n++) begin
      logic [23:0] tagv;
      logic [5:0]  idx;
      logic [31:0] a;
      logic [31:0] d;
      int          rb;
      int          lat;
      bit          h;
      int          sel;
      sel = $urandom_range(0, 2);
      tagv = (sel == 0) ? 24'h0 : (sel == 1) ? 24'h1 : 24'hABCDE;
      idx = 6'($urandom_range(0, 7));
      a   = {tagv, idx, 2'($urandom_range(0, 3))};
      d   = $urandom;
      rb  = $urandom_range(0, 5);
      rb  = (rb < 4) ? 0 : rb - 3;
      lat = $urandom_range(1, 5);
      if (rb == 1 && lat < 2) lat = 2;
      h = m_valid[idx] && (m_tag[idx] == tagv);
      fetch($sformatf("rnd%0d", n), a, rb, lat, d, h, h || (rb == 0), h ? m_data[idx] : d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller.
- Serves fetch requests on a hit with 1-cycle latency.
- On a miss, issues a single word request to the memory controller, fills the line, then answers the fetcher.
- Accepts a rollback signal so a mispredicted fetch in flight is not delivered.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines, 256 B of instruction data).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  discard the current/pending fetch (branch mispredict)
- inst_IF_req  in  1  fetch request, level, held until inst_IF_flag
- inst_IF_addr  in  32  fetch PC; bits [1:0] ignored
- inst_IF_flag  out  1  one-cycle pulse: inst_IF valid
- inst_IF  out  32  fetched instruction
- inst_MC_req  out  1  word request to memory controller, level
- inst_MC_addr  out  32  word address of miss ({tag,index,2'b00})
- inst_MC_flag  in  1  memory controller word ready (one-cycle pulse)
- inst_MC  in  32  word returned by memory controller

Interface rule: one clock `clk`; `rst` is synchronous and active-high.

Behaviour:
- Address split: index = addr[INDEX_WIDTH+1:2]; tag = addr[31:INDEX_WIDTH+2].
- Storage per line: valid bit, tag (32-INDEX_WIDTH-2 bits), 32-bit data. All state is updated only on posedge clk when rdy=1.
- Reset (rst=1, regardless of rdy):
  - all valid bits cleared, state=IDLE.
  - inst_IF_flag=0, inst_IF=0, inst_MC_req=0, inst_MC_addr=0, internal discard flag=0.
- rdy=0: no register changes; outputs hold their current values.
- FSM, IDLE:
  - Default: inst_IF_flag<=0.
  - inst_IF_req=1, rollback=0, hit: next cycle inst_IF_flag=1 and inst_IF=data[index]; stay IDLE. Hit latency is 1 cycle.
  - inst_IF_req=1, rollback=0, miss: latch the address; inst_MC_req<=1 and inst_MC_addr<={addr[31:2],2'b00}; go MISS.
  - rollback=1: the request is ignored this cycle; no flag, no MC request.
  - inst_MC_flag in IDLE is ignored.
- FSM, MISS:
  - inst_MC_req and inst_MC_addr are held stable until inst_MC_flag.
  - inst_MC_flag=1: write valid=1, tag and data at the latched index.
    - inst_MC_req<=0; go IDLE.
    - If discard=0 and rollback=0: inst_IF_flag<=1, inst_IF<=inst_MC.
    - Otherwise: no flag. The line is still filled; the memory controller cannot abort.
    - discard<=0.
  - rollback=1 without inst_MC_flag: discard<=1; remain MISS.
  - New fetcher requests are not sampled in MISS. The fetcher must hold req/addr until the flag, or drop req after rollback.
- inst_IF_flag is high for exactly one cycle per delivered instruction.
- A hit back-to-back after a flag is allowed: a new request can be served in the cycle after a flag (throughput 1 per 2 cycles minimum, since the fetcher sees the flag and then presents the next PC).
- Same index, different tag: the miss replaces the line (no associativity).
- rst during MISS: state returns to IDLE and inst_MC_req drops the next cycle. A late inst_MC_flag arriving in IDLE is ignored.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared defines header, already used codebase-wide: `True/`False, and an ICACHE_STATE width with state encodings ICACHE_IDLE=1'b0 and ICACHE_MISS=1'b1.
- Tag/index width derivation stays local to the module via INDEX_WIDTH.
- Storage arrays are inferred inline; no sub-module is warranted at this size.

Test Plan:
- Cold miss: after reset, req addr=0x00000000 → inst_MC_req=1 with inst_MC_addr=0x0 next cycle. MC returns 0x00000013 after 4 cycles → inst_IF_flag=1 pulse, inst_IF=0x00000013, inst_MC_req=0.
- Hit: repeat addr=0x0 → inst_IF_flag=1 one cycle after req, inst_IF=0x00000013, inst_MC_req stays 0.
- Conflict: req 0x00000100 (same index 0, different tag) → miss issued with addr 0x100. Fill 0xFFF00093. A subsequent req 0x0 misses again.
- Rollback mid-miss: req 0x4 misses; rollback pulse 2 cycles later; MC returns 0x00100113 → no inst_IF_flag. A following req 0x4 hits with 0x00100113.
- rdy stall: rdy=0 for 3 cycles during a hit response → inst_IF_flag/inst_IF held, no state change. After rdy=1, the flag deasserts the next cycle.
- Reset mid-miss: rst asserted while inst_MC_req=1 → next cycle inst_MC_req=0 and all outputs 0. A late inst_MC_flag is ignored. Req 0x0 afterwards misses (valid bits cleared).
